// File: rtl/transpose_buffer_array.sv
// ============================================================================
// Module  : transpose_buffer_array
// Purpose : Self-sequencing SIZE x SIZE transpose buffer; emits the transpose
//           of the previous block by flipping the cell shift direction at
//           every block boundary. Optional TRANSPOSE_BUFFER_BYPASS_EN adds a
//           'transpose' input that can hold the direction (delay-only block).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module transpose_buffer_array #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                       flush,
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
  input  logic                       transpose,
`endif
  output logic                       ready,
  output logic                       out_valid,
  output logic                       out_first,
  output logic [SIZE*DATA_WIDTH-1:0] out_data
);

  localparam int             CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SIZE - 1);

  logic [DATA_WIDTH-1:0] cells     [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] cells_nxt [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] lane_in   [SIZE];
  logic [SIZE*DATA_WIDTH-1:0] out_nxt;
  logic             dir;
  logic [CNT_W-1:0] beat_cnt;
  logic             primed;
  logic             draining;
  logic             flush_ok;
  logic             shift;
  logic             wrap;
  logic             toggle;

  assign ready    = !draining;
  assign flush_ok = flush & primed & (beat_cnt == '0) & !draining;
  // an accepted flush suppresses the shift, so a simultaneous input beat is dropped
  assign shift    = !flush_ok & ((in_valid & ready) | draining);
  assign wrap     = shift & (beat_cnt == LAST_BEAT);

`ifdef TRANSPOSE_BUFFER_BYPASS_EN
  assign toggle = transpose;
`else
  assign toggle = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      lane_in[i] = draining ? '0 : in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // dir=0 pops row 0 and pushes rows upward; dir=1 pops column 0 and pushes left
  always_comb begin
    cells_nxt = cells;
    out_nxt   = '0;
    for (int i = 0; i < SIZE; i++) begin
      out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = dir ? cells[i][0] : cells[0][i];
    end
    if (!dir) begin
      for (int r = 0; r < SIZE - 1; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          cells_nxt[r][k] = cells[r+1][k];
        end
      end
      for (int k = 0; k < SIZE; k++) begin
        cells_nxt[SIZE-1][k] = lane_in[k];
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE - 1; k++) begin
          cells_nxt[i][k] = cells[i][k+1];
        end
        cells_nxt[i][SIZE-1] = lane_in[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          cells[r][k] <= '0;
        end
      end
      dir       <= 1'b0;
      beat_cnt  <= '0;
      primed    <= 1'b0;
      draining  <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= shift & primed;
      out_first <= shift & primed & (beat_cnt == '0);
      if (flush_ok) begin
        draining <= 1'b1;
      end
      if (shift) begin
        cells    <= cells_nxt;
        out_data <= out_nxt;
        if (wrap) begin
          beat_cnt <= '0;
          dir      <= dir ^ toggle;
          if (draining) begin
            draining <= 1'b0;
            primed   <= 1'b0;
          end else begin
            primed   <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_transpose_buffer_array.sv
// ============================================================================
// Module  : tb_transpose_buffer_array
// Purpose : Self-checking bench for transpose_buffer_array (block-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_transpose_buffer_array;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [N*DW-1:0]   in_data;
  logic              flush;
  logic              ready;
  logic              out_valid;
  logic              out_first;
  logic [N*DW-1:0]   out_data;
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
  logic              transpose;
`endif

  transpose_buffer_array #(.DATA_WIDTH(DW), .SIZE(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
    .transpose (transpose),
`endif
    .ready     (ready),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // block-level reference: previous complete block and block being collected
  logic [DW-1:0] m_prev [N][N];
  logic [DW-1:0] m_cur  [N][N];
  int            m_cnt;
  bit            m_primed;
  bit            m_drain;
  bit            m_tr;

  typedef struct {
    bit              v;
    logic [N*DW-1:0] d;
    bit              ev;
    bit              ef;
    logic [N*DW-1:0] ed;
  } vec_t;
  vec_t tab [9];

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N*DW-1:0] rnd_vec();
    logic [N*DW-1:0] v;
    for (int l = 0; l < N; l++) begin
      case ($urandom_range(0, 5))
        0:       v[l*DW +: DW] = 8'h80;
        1:       v[l*DW +: DW] = 8'h7f;
        default: v[l*DW +: DW] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        m_prev[r][k] = '0;
        m_cur[r][k]  = '0;
      end
    m_cnt = 0; m_primed = 0; m_drain = 0; m_tr = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_first", {31'd0, out_first}, 32'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // one clock: drive inputs, predict with the model, check after the edge
  task automatic cycle(input bit v, input logic [N*DW-1:0] d, input bit f, input bit t);
    bit fl, sh, ev, ef;
    logic [N*DW-1:0] ed;
    in_valid = v; in_data = d; flush = f;
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
    transpose = t;
`endif
    chk("ready", {31'd0, ready}, {31'd0, !m_drain});
    fl = f && m_primed && m_cnt == 0 && !m_drain;
    sh = !fl && ((v && !m_drain) || m_drain);
    ev = 0; ef = 0; ed = '0;
    if (fl) begin
      m_drain = 1;
    end else if (sh) begin
      ev = m_primed;
      ef = m_primed && m_cnt == 0;
      for (int i = 0; i < N; i++)
        ed[i*DW +: DW] = m_tr ? m_prev[i][m_cnt] : m_prev[m_cnt][i];
      for (int l = 0; l < N; l++)
        m_cur[m_cnt][l] = m_drain ? '0 : d[l*DW +: DW];
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt  = 0;
        m_prev = m_cur;
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
        m_tr = t;
`else
        m_tr = 1;
`endif
        if (m_drain) begin m_drain = 0; m_primed = 0; end
        else m_primed = 1;
      end
    end
    @(posedge clock); #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("out_first", {31'd0, out_first}, {31'd0, ef});
    if (ev) chk("out_data", out_data, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef TRANSPOSE_BUFFER_BYPASS_EN
    transpose = 1'b1;
`endif
    model_reset();
    // directed table: block0 beat b lane l = 16b+l, block1 = 64+16b+l
    for (int e = 0; e < 9; e++) begin
      tab[e].v  = (e < 8);
      tab[e].d  = '0;
      tab[e].ev = (e >= 4 && e < 8);
      tab[e].ef = (e == 4);
      tab[e].ed = '0;
      for (int l = 0; l < N; l++) begin
        if (e < 8) tab[e].d[l*DW +: DW] = DW'((e / 4) * 64 + 16 * (e % 4) + l);
        if (e >= 4) tab[e].ed[l*DW +: DW] = DW'(16 * l + ((e < 8) ? e - 4 : 3));
      end
    end

    do_reset();
    for (int e = 0; e < 9; e++) begin
      in_valid = tab[e].v; in_data = tab[e].d; flush = 1'b0;
      chk("tab_ready", {31'd0, ready}, 32'd1);
      @(posedge clock); #1;
      chk($sformatf("tab_valid[%0d]", e), {31'd0, out_valid}, {31'd0, tab[e].ev});
      chk($sformatf("tab_first[%0d]", e), {31'd0, out_first}, {31'd0, tab[e].ef});
      chk($sformatf("tab_data[%0d]", e), out_data, tab[e].ed);
    end

    // continuous random blocks
    do_reset();
    for (int c = 0; c < 5 * N; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);
    // in_valid toggling every cycle
    for (int c = 0; c < 6 * N; c++) cycle(c[0] == 1'b0, rnd_vec(), 1'b0, 1'b1);

    // flush at a block boundary: drain held block, inputs refused meanwhile
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int c = 0; c < N; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);

    // flush mid-block is ignored
    for (int c = 0; c < N + 2; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int c = 0; c < N + 2; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);

    // flush together with a valid beat: flush wins
    cycle(1'b1, rnd_vec(), 1'b1, 1'b1);
    for (int c = 0; c < N + 1; c++) cycle(1'b0, '0, 1'b0, 1'b1);

    // asynchronous reset at beat 2 of block 1
    for (int c = 0; c < N + 2; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);
    do_reset();
    for (int c = 0; c < N + 3; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);

`ifdef TRANSPOSE_BUFFER_BYPASS_EN
    for (int c = 0; c < 6 * N; c++) cycle(1'b1, rnd_vec(), 1'b0, bit'($urandom_range(0, 1)));
    for (int c = 0; c < N; c++) cycle(1'b1, rnd_vec(), 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
